mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port opcode, input, 6 bits: instruction[31:26] from the instruction register.
REQ-005 SHALL have port funct, input, 6 bits: instruction[5:0].
REQ-006 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory access complete this cycle.
REQ-008 SHALL have these outputs, 1 bit each: PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcA, halted.
REQ-009 SHALL have these outputs, 2 bits each: RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource.
REQ-010 SHALL have output state, 4 bits: current FSM state.
REQ-011 SHALL have output instr_count, CNT_W bits: retired-instruction count.

Function
REQ-012 SHALL implement these FSM states: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP, JAL, JR, ADDI_EXEC, ADDI_WB, HALT.
REQ-013 SHALL drive every output to 0 unless this section lists a value for the current state.
REQ-014 In FETCH, SHALL drive MemRead=1, ALUSrcB=01, and IRWrite=PCWrite=mem_ready; SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-015 In DECODE, SHALL drive ALUSrcB=11 and SHALL select the next state from opcode:
- 000000 with funct 001000 -> JR
- other 000000 -> R_EXEC
- 100011 or 101011 -> MEM_ADDR
- 000100 -> BRANCH
- 001000 -> ADDI_EXEC
- 000010 -> JUMP
- 000011 -> JAL
- any other opcode -> HALT
REQ-016 In MEM_ADDR, SHALL drive ALUSrcA=1 and ALUSrcB=10, then go to MEM_READ for lw or MEM_WRITE for sw.
REQ-017 In MEM_READ, SHALL drive MemRead=1, hold while mem_ready=0, and go to MEM_WB when mem_ready=1.
REQ-018 In MEM_WB, SHALL drive RegWrite=1, RegDst=00 and MemtoReg=01, then go to FETCH.
REQ-019 In MEM_WRITE, SHALL drive MemWrite=1, hold while mem_ready=0, and go to FETCH when mem_ready=1.
REQ-020 In R_EXEC, SHALL drive ALUSrcA=1 and ALUOp=10, then go to R_WB.
REQ-021 In R_WB, SHALL drive RegWrite=1 and RegDst=01, then go to FETCH.
REQ-022 In BRANCH, SHALL drive ALUSrcA=1, ALUOp=01, PCSource=01 and PCWrite=zero, then go to FETCH.
REQ-023 In JUMP, SHALL drive PCSource=10 and PCWrite=1, then go to FETCH.
REQ-024 In JAL, SHALL drive the JUMP outputs plus RegWrite=1, RegDst=10 and MemtoReg=10, then go to FETCH.
REQ-025 In JR, SHALL drive PCSource=11 and PCWrite=1, then go to FETCH.
REQ-026 In ADDI_EXEC, SHALL drive ALUSrcA=1 and ALUSrcB=10, then go to ADDI_WB.
REQ-027 In ADDI_WB, SHALL drive RegWrite=1 and RegDst=00, then go to FETCH.
REQ-028 In HALT, SHALL drive halted=1 with all enables 0, and SHALL remain in HALT until reset.
REQ-029 SHALL compute outputs combinationally from state, plus zero and mem_ready where listed above.
REQ-030 SHALL increment instr_count by 1 on each transition into FETCH from a non-FETCH state, and SHALL wrap modulo 2^CNT_W.
REQ-031 SHALL assert MemRead and MemWrite in mutually exclusive states only.
REQ-032 SHALL set cycle counts as follows:
- lw: 5 cycles
- sw: 4 cycles
- R-type: 4 cycles
- addi: 4 cycles
- beq, j, jal, jr: 3 cycles
- each mem_ready=0 cycle adds 1 cycle to the above.

Reset
REQ-033 While reset=1 at a clock edge, SHALL set state=FETCH and instr_count=0, with priority over every transition, including mid-instruction and in HALT.
REQ-034 SHALL hold IRWrite, PCWrite, MemWrite and RegWrite at 0 in the cycle after reset is released until FETCH sees mem_ready=1.

Structure
REQ-035 SHALL take the state encodings, opcode/funct constants and mux-select codes (RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp) from a shared include file, mips_ctrl_defs, which datapath blocks also use.
REQ-036 SHALL place the opcode-to-next-state decode in one combinational sub-module, mc_dispatch; state register, counter and output decode remain in this module.

Verification
REQ-037 Reset mid-MEM_READ: reset=1 for one cycle -> next cycle state=FETCH, instr_count=0, RegWrite=0.
REQ-038 lw (opcode 100011), mem_ready=1 throughout -> states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH; instr_count +1; MEM_WB outputs RegWrite=1, MemtoReg=01.
REQ-039 sw with mem_ready=0 for 3 cycles in MEM_WRITE -> MemWrite=1 for 4 cycles, then FETCH.
REQ-040 beq with zero=1, then beq with zero=0 -> PCWrite=1 with PCSource=01 in the first BRANCH, PCWrite=0 in the second.
REQ-041 jal, then jr (000000/001000) -> JAL drives RegDst=10, MemtoReg=10, PCSource=10; JR drives PCSource=11, RegWrite=0.
REQ-042 Opcode 111111 -> HALT, halted=1 for all later cycles; preload instr_count=2^CNT_W-1, retire one instruction -> instr_count=0.

Source files
------------

// File: rtl/mips_ctrl_defs.sv
// mips_ctrl_defs: shared constants for the multicycle MIPS control path.
// Holds the FSM state encoding, the opcode/funct constants and the mux-select
// codes that both this controller and the datapath blocks decode.
package mips_ctrl_defs;

  // Controller FSM states; the 4-bit encoding is visible on the state port.
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    JAL       = 4'd10,
    JR        = 4'd11,
    ADDI_EXEC = 4'd12,
    ADDI_WB   = 4'd13,
    HALT      = 4'd14
  } state_t;

  // Opcode field, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Funct field, instruction[5:0]
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // RegDst: register-file write address select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // MemtoReg: register-file write data select
  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  // ALUSrcB: ALU operand B select
  localparam logic [1:0] ALUSRCB_REG    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

  // ALUOp: ALU control class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PCSource: next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

endpackage

// File: rtl/mc_dispatch.sv
// mc_dispatch: combinational instruction dispatch for the multicycle controller.
// Ports:
//   opcode      - instruction[31:26]
//   funct       - instruction[5:0]
//   decode_next - state entered after DECODE
//   mem_next    - state entered after MEM_ADDR (MEM_READ for lw, MEM_WRITE for sw)
module mc_dispatch
  import mips_ctrl_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_t     decode_next,
  output state_t     mem_next
);

  always_comb begin
    decode_next = HALT;
    case (opcode)
      OP_RTYPE: decode_next = (funct == FUNCT_JR) ? JR : R_EXEC;
      OP_LW,
      OP_SW:    decode_next = MEM_ADDR;
      OP_BEQ:   decode_next = BRANCH;
      OP_ADDI:  decode_next = ADDI_EXEC;
      OP_J:     decode_next = JUMP;
      OP_JAL:   decode_next = JAL;
      default:  decode_next = HALT;
    endcase
  end

  // Only lw and sw reach MEM_ADDR, so a single opcode compare splits them.
  always_comb begin
    mem_next = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   opcode, funct          - instruction fields from the instruction register
//   zero                   - ALU zero flag (gates PCWrite in BRANCH)
//   mem_ready              - memory access completes this cycle
//   PCWrite .. halted      - 1-bit datapath enables / status
//   RegDst .. PCSource     - 2-bit datapath mux selects
//   state                  - current FSM state encoding
//   instr_count            - retired-instruction counter, wraps mod 2^CNT_W
module mips_multicycle_ctrl
  import mips_ctrl_defs::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic             halted,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q;
  state_t           state_d;
  state_t           decode_next;
  state_t           mem_next;
  logic [CNT_W-1:0] instr_count_q;

  mc_dispatch u_dispatch (
    .opcode      (opcode),
    .funct       (funct),
    .decode_next (decode_next),
    .mem_next    (mem_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     state_d = mem_ready ? DECODE : FETCH;
      DECODE:    state_d = decode_next;
      MEM_ADDR:  state_d = mem_next;
      MEM_READ:  state_d = mem_ready ? MEM_WB : MEM_READ;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
      R_EXEC:    state_d = R_WB;
      R_WB:      state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JUMP:      state_d = FETCH;
      JAL:       state_d = FETCH;
      JR:        state_d = FETCH;
      ADDI_EXEC: state_d = ADDI_WB;
      ADDI_WB:   state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase
  end

  // Output decode; everything not listed for a state stays 0.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    halted   = 1'b0;
    RegDst   = '0;
    MemtoReg = '0;
    ALUSrcB  = '0;
    ALUOp    = '0;
    PCSource = '0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = ALUSRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB = ALUSRCB_BRANCH;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_IMM;
      end
      MEM_READ: begin
        MemRead = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RT;
        MemtoReg = MEMTOREG_MEM;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RD;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALUOP_SUB;
        PCSource = PCSRC_BRANCH;
        PCWrite  = zero;
      end
      JUMP: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
      end
      JAL: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
        RegWrite = 1'b1;
        RegDst   = REGDST_RA;
        MemtoReg = MEMTOREG_PC;
      end
      JR: begin
        PCSource = PCSRC_REG;
        PCWrite  = 1'b1;
      end
      ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_IMM;
      end
      ADDI_WB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RT;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // An instruction retires on every return to FETCH from elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count_q <= '0;
    end else if ((state_d == FETCH) && (state_q != FETCH)) begin
      instr_count_q <= instr_count_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

  a_mem_excl: assert property (@(posedge clk) !(MemRead && MemWrite));

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;
  import mips_ctrl_defs::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          zero;
  logic          mem_ready;
  logic          PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcA, halted;
  logic [1:0]    RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  mips_multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .IRWrite     (IRWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .halted      (halted),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .state       (state),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [CW-1:0] model_cnt;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         fw;
    int         mw;
    int         exp_cycles;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Expected {state, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcA,
  // halted, RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource} for one cycle.
  function automatic logic [20:0] expect_outs(state_t st, logic z, logic mr);
    logic       pcw, irw, mrd, mwr, rw, asa, hl;
    logic [1:0] rd, m2r, asb, aop, pcs;
    pcw = 0; irw = 0; mrd = 0; mwr = 0; rw = 0; asa = 0; hl = 0;
    rd = 0; m2r = 0; asb = 0; aop = 0; pcs = 0;
    case (st)
      FETCH:     begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      DECODE:    asb = 2'b11;
      MEM_ADDR:  begin asa = 1; asb = 2'b10; end
      MEM_READ:  mrd = 1;
      MEM_WB:    begin rw = 1; rd = 2'b00; m2r = 2'b01; end
      MEM_WRITE: mwr = 1;
      R_EXEC:    begin asa = 1; aop = 2'b10; end
      R_WB:      begin rw = 1; rd = 2'b01; end
      BRANCH:    begin asa = 1; aop = 2'b01; pcs = 2'b01; pcw = z; end
      JUMP:      begin pcs = 2'b10; pcw = 1; end
      JAL:       begin pcs = 2'b10; pcw = 1; rw = 1; rd = 2'b10; m2r = 2'b10; end
      JR:        begin pcs = 2'b11; pcw = 1; end
      ADDI_EXEC: begin asa = 1; asb = 2'b10; end
      ADDI_WB:   begin rw = 1; rd = 2'b00; end
      HALT:      hl = 1;
      default:   ;
    endcase
    return {4'(st), pcw, irw, mrd, mwr, rw, asa, hl, rd, m2r, asb, aop, pcs};
  endfunction

  function automatic logic [20:0] actual_outs();
    return {state, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcA, halted,
            RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    model_cnt = '0;
  endtask

  // Runs one instruction from FETCH. The expected walk is derived from the
  // instruction class, with fw/mw extra not-ready cycles in FETCH and in the
  // memory-access phase. Other inputs are randomised where they must not matter.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw, output int cycles);
    state_t seq[$];
    logic   mrs[$];
    for (int i = 0; i < fw; i++) begin seq.push_back(FETCH); mrs.push_back(1'b0); end
    seq.push_back(FETCH);  mrs.push_back(1'b1);
    seq.push_back(DECODE); mrs.push_back(1'($urandom));
    if (op == 6'b000000 && fn == 6'b001000) begin
      seq.push_back(JR); mrs.push_back(1'($urandom));
    end else if (op == 6'b000000) begin
      seq.push_back(R_EXEC); mrs.push_back(1'($urandom));
      seq.push_back(R_WB);   mrs.push_back(1'($urandom));
    end else if (op == 6'b100011 || op == 6'b101011) begin
      seq.push_back(MEM_ADDR); mrs.push_back(1'($urandom));
      for (int i = 0; i <= mw; i++) begin
        seq.push_back(op == 6'b100011 ? MEM_READ : MEM_WRITE);
        mrs.push_back(i == mw);
      end
      if (op == 6'b100011) begin seq.push_back(MEM_WB); mrs.push_back(1'($urandom)); end
    end else if (op == 6'b000100) begin
      seq.push_back(BRANCH); mrs.push_back(1'($urandom));
    end else if (op == 6'b001000) begin
      seq.push_back(ADDI_EXEC); mrs.push_back(1'($urandom));
      seq.push_back(ADDI_WB);   mrs.push_back(1'($urandom));
    end else if (op == 6'b000010) begin
      seq.push_back(JUMP); mrs.push_back(1'($urandom));
    end else if (op == 6'b000011) begin
      seq.push_back(JAL); mrs.push_back(1'($urandom));
    end else begin
      seq.push_back(HALT); mrs.push_back(1'($urandom));
    end
    for (int i = 0; i < seq.size(); i++) begin
      opcode    = op;
      funct     = fn;
      mem_ready = mrs[i];
      zero      = (seq[i] == BRANCH) ? z : 1'($urandom);
      #1;
      check($sformatf("cycle_%s", seq[i].name()), 32'(actual_outs()),
            32'(expect_outs(seq[i], zero, mem_ready)));
      tick();
    end
    cycles = seq.size();
    if (seq[seq.size()-1] != HALT) model_cnt = model_cnt + 1'b1;
    check("instr_count", 32'(instr_count), 32'(model_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int   cyc;
    logic [5:0] op_pool[8];

    tbl[0] = '{6'b100011, 6'b000000, 1'b0, 0, 0, 5}; // lw
    tbl[1] = '{6'b101011, 6'b000000, 1'b0, 0, 3, 7}; // sw, 3 wait cycles
    tbl[2] = '{6'b000000, 6'b100000, 1'b0, 0, 0, 4}; // add
    tbl[3] = '{6'b001000, 6'b000000, 1'b0, 0, 0, 4}; // addi
    tbl[4] = '{6'b000100, 6'b000000, 1'b1, 0, 0, 3}; // beq taken
    tbl[5] = '{6'b000100, 6'b000000, 1'b0, 0, 0, 3}; // beq not taken
    tbl[6] = '{6'b000010, 6'b000000, 1'b0, 0, 0, 3}; // j
    tbl[7] = '{6'b000011, 6'b000000, 1'b0, 0, 0, 3}; // jal
    tbl[8] = '{6'b000000, 6'b001000, 1'b0, 0, 0, 3}; // jr
    tbl[9] = '{6'b100011, 6'b000000, 1'b0, 2, 1, 8}; // lw, fetch and mem waits

    op_pool = '{6'b100011, 6'b101011, 6'b000000, 6'b001000,
                6'b000100, 6'b000010, 6'b000011, 6'b000000};

    opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0; reset = 1'b1;
    model_cnt = '0;
    @(negedge clk);
    tick();
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    // Right after reset: FETCH with enables gated off until mem_ready
    check("reset_outs", 32'(actual_outs()), 32'(expect_outs(FETCH, 1'b0, 1'b0)));
    check("reset_count", 32'(instr_count), 32'(0));
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].fw, tbl[i].mw, cyc);
      check($sformatf("cycles_vec%0d", i), 32'(cyc), 32'(tbl[i].exp_cycles));
    end

    // Reset while stalled in MEM_READ
    opcode = 6'b100011; funct = '0; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick();
    #1;
    check("in_mem_read", 32'(state), 32'(4'(MEM_READ)));
    @(negedge clk);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_ready = 1'b0;
    model_cnt = '0;
    #1;
    check("midrst_state", 32'(state), 32'(4'(FETCH)));
    check("midrst_count", 32'(instr_count), 32'(0));
    check("midrst_regwrite", 32'(RegWrite), 32'(0));
    check("midrst_outs", 32'(actual_outs()), 32'(expect_outs(FETCH, 1'b0, 1'b0)));
    @(negedge clk);

    // Randomised instruction stream; counter wraps several times at CW=4
    for (int n = 0; n < 150; n++) begin
      int unsigned k;
      logic [5:0]  fn;
      k  = $urandom_range(7);
      fn = 6'($urandom);
      if (k == 7) fn = 6'b001000;
      else if (fn == 6'b001000) fn = 6'b100010;
      run_instr(op_pool[k], fn, 1'($urandom), int'($urandom_range(2)),
                int'($urandom_range(3)), cyc);
    end

    // Counter wrap from all-ones to zero
    do_reset();
    for (int n = 0; n < 15; n++) run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, cyc);
    check("count_max", 32'(instr_count), 32'((1 << CW) - 1));
    run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, cyc);
    check("count_wrap", 32'(instr_count), 32'(0));

    // Halt is sticky, counter frozen
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, cyc);
    for (int n = 0; n < 6; n++) begin
      opcode = 6'($urandom); funct = 6'($urandom);
      zero = 1'($urandom); mem_ready = 1'($urandom);
      #1;
      check("halt_hold", 32'(actual_outs()), 32'(expect_outs(HALT, zero, mem_ready)));
      check("halt_count", 32'(instr_count), 32'(model_cnt));
      tick();
    end

    // Reset leaves HALT; another undefined opcode halts again
    do_reset();
    mem_ready = 1'b0;
    #1;
    check("halt_reset_state", 32'(state), 32'(4'(FETCH)));
    check("halt_reset_count", 32'(instr_count), 32'(0));
    @(negedge clk);
    run_instr(6'b000001, 6'b000000, 1'b0, 1, 0, cyc);
    check("halt2_cycles", 32'(cyc), 32'(4));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
